// File: rtl/dff_en_clr.sv
// dff_en_clr: gated D flip-flop with asynchronous active-low clear
module dff_en_clr #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= RESET_VALUE;
        else if (en) q <= d;
endmodule

// File: tb/tb_dff_en_clr.sv
// tb_dff_en_clr: directed checks of the 1-bit default and an 8-bit instance
module tb_dff_en_clr;
    logic       clk = 1'b0;
    logic       clr, en, d;
    logic       q;
    logic       clr_w, en_w;
    logic [7:0] d_w, q_w;
    int         errors = 0;
    int         checks = 0;

    dff_en_clr u_dut (.clk(clk), .clr(clr), .en(en), .d(d), .q(q));
    dff_en_clr #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_wide (
        .clk(clk), .clr(clr_w), .en(en_w), .d(d_w), .q(q_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] seq;
        seq = 6'b110011;
        clr = 1'b0; en = 1'b0; d = 1'b0;
        clr_w = 1'b0; en_w = 1'b0; d_w = 8'h00;
        tick();
        check("reset", {7'b0, q}, 8'h00);
        check("wide_reset", q_w, 8'hA5);

        clr = 1'b1; en = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            d = seq[i];
            tick();
            check($sformatf("load%0d", 5 - i), {7'b0, q}, {7'b0, seq[i]});
        end

        en = 1'b0; d = 1'b0;
        tick();
        check("hold0", {7'b0, q}, 8'h01);
        tick();
        check("hold1", {7'b0, q}, 8'h01);
        en = 1'b1;
        tick();
        check("hold_release", {7'b0, q}, 8'h00);

        d = 1'b1;
        tick();
        check("preload", {7'b0, q}, 8'h01);
        #2 d = 1'b0; en = 1'b0;
        #1 check("between_edges", {7'b0, q}, 8'h01);
        en = 1'b1; d = 1'b1;
        @(posedge clk);
        #2 clr = 1'b0;
        #1 check("async_clear", {7'b0, q}, 8'h00);
        @(negedge clk);
        tick();
        check("clear_prio0", {7'b0, q}, 8'h00);
        tick();
        check("clear_prio1", {7'b0, q}, 8'h00);

        // clr released in the NBA region so the flop still sees it low on this edge
        @(posedge clk);
        clr <= 1'b1;
        @(negedge clk);
        check("release_edge", {7'b0, q}, 8'h00);
        tick();
        check("release_next", {7'b0, q}, 8'h01);

        clr_w = 1'b1; en_w = 1'b1; d_w = 8'h11;
        tick();
        check("wide_pre", q_w, 8'h11);
        #2 clr_w = 1'b0;
        #1 check("wide_async", q_w, 8'hA5);
        d_w = 8'h3C;
        @(negedge clk);
        tick();
        check("wide_held", q_w, 8'hA5);
        clr_w = 1'b1;
        tick();
        check("wide_load", q_w, 8'h3C);
        en_w = 1'b0; d_w = 8'hFF;
        tick();
        check("wide_hold", q_w, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
